// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receive controller: register map,
// STATUS/CTRL bit positions and the capture FSM state encoding.
package uart_rx_ctrl_pkg;

    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_CTRL   = 4'h8;

    localparam int ST_NEMPTY = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_OVR    = 2;
    localparam int ST_PERR   = 3;

    localparam int CT_RXEN   = 0;
    localparam int CT_IRQEN  = 1;
    localparam int CT_FLUSH  = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_PUSH  = 2'd2
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous frame FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle, and flush overrides both.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointers are exactly AW bits wide so they wrap modulo DEPTH for free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Memory-mapped UART receive controller: captures frames on rx_ready rising
// edges, checks parity, buffers them and exposes DATA/STATUS/CTRL registers.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  rx_frame,
    input  logic        rx_ready,
    input  logic        sel,
    input  logic [3:0]  addr,
    input  logic        re,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    rx_state_t   state;
    logic [8:0]  hold;
    logic        perr;
    logic        rdy_q;
    logic        rx_edge;
    logic        rx_en;
    logic        irq_en;
    logic        ovr;
    logic        perr_sticky;

    logic        rd_data;
    logic        wr_status;
    logic        wr_ctrl;
    logic        flush_now;

    logic        fifo_push;
    logic        fifo_pop;
    logic [8:0]  fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic [CW-1:0] fifo_count;

    logic        ovr_set;
    logic        perr_set;
    logic [31:0] status_word;
    logic        unused_wdata;

    assign unused_wdata = ^wdata[31:4];

    assign rx_edge   = rx_ready && !rdy_q;
    assign rd_data   = sel && re && (addr == ADDR_DATA);
    assign wr_status = sel && we && (addr == ADDR_STATUS);
    assign wr_ctrl   = sel && we && (addr == ADDR_CTRL);
    assign flush_now = wr_ctrl && wdata[CT_FLUSH];

    assign fifo_push = (state == S_PUSH) && !flush_now;
    assign fifo_pop  = rd_data;

    // A full FIFO only drops the frame when no pop frees a slot this cycle;
    // an edge arriving mid-capture is also lost and reported as overrun.
    assign ovr_set  = (fifo_push && fifo_full && !fifo_pop)
                    || (rx_edge && (state != S_IDLE));
    assign perr_set = (state == S_PUSH) && perr;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (flush_now),
        .din   ({perr, hold[7:0]}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdy_q <= 1'b0;
        else     rdy_q <= rx_ready;
    end

    // Capture FSM: latch the frame, evaluate parity, then hand it to the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            hold  <= '0;
            perr  <= 1'b0;
        end else if (flush_now) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_edge && rx_en) begin
                        hold  <= rx_frame;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    perr  <= PARITY_EN && ((^hold) != PARITY_ODD);
                    state <= S_PUSH;
                end
                S_PUSH:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_en  <= 1'b0;
            irq_en <= 1'b0;
        end else if (wr_ctrl) begin
            rx_en  <= wdata[CT_RXEN];
            irq_en <= wdata[CT_IRQEN];
        end
    end

    // Sticky flags: write-1-to-clear, with a same-cycle set taking priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr         <= 1'b0;
            perr_sticky <= 1'b0;
        end else begin
            ovr         <= ovr_set  || (ovr && !(wr_status && wdata[ST_OVR]));
            perr_sticky <= perr_set || (perr_sticky && !(wr_status && wdata[ST_PERR]));
        end
    end

    always_comb begin
        status_word            = '0;
        status_word[ST_NEMPTY] = !fifo_empty;
        status_word[ST_FULL]   = fifo_full;
        status_word[ST_OVR]    = ovr;
        status_word[ST_PERR]   = perr_sticky;
        status_word[8:4]       = 5'(fifo_count);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (sel && re) begin
            case (addr)
                ADDR_DATA:   rdata <= fifo_empty ? 32'd0 : {23'd0, fifo_dout};
                ADDR_STATUS: rdata <= status_word;
                ADDR_CTRL:   rdata <= {30'd0, irq_en, rx_en};
                default:     rdata <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq <= 1'b0;
        else     irq <= irq_en && (!fifo_empty || ovr || perr_sticky);
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based model.
module tb_uart_rx_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  rx_frame;
    logic        rx_ready;
    logic        sel;
    logic [3:0]  addr;
    logic        re;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [8:0]  frame;
        logic [31:0] exp_data;
        logic [31:0] exp_status;
    } vec_t;

    vec_t vecs [6];

    logic [8:0] mq [$];
    bit         m_ovr;
    bit         m_perr;

    uart_rx_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .rx_frame (rx_frame),
        .rx_ready (rx_ready),
        .sel      (sel),
        .addr     (addr),
        .re       (re),
        .we       (we),
        .wdata    (wdata),
        .rdata    (rdata),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input logic [3:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick();
        sel = 1'b0; we = 1'b0; wdata = '0;
    endtask

    task automatic busRead(input logic [3:0] a, output logic [31:0] d);
        sel = 1'b1; re = 1'b1; addr = a;
        tick();
        sel = 1'b0; re = 1'b0;
        d = rdata;
    endtask

    task automatic applyStimulus(input logic [8:0] f, input int hold_cycles);
        rx_frame = f;
        rx_ready = 1'b1;
        repeat (hold_cycles) tick();
        rx_ready = 1'b0;
        repeat (4) tick();
    endtask

    // Even-parity frame: received parity bit makes the 9-bit ones count even.
    function automatic logic [8:0] goodFrame(input logic [7:0] d);
        return {^d, d};
    endfunction

    function automatic logic [31:0] modelStatus();
        logic [31:0] s;
        s      = '0;
        s[0]   = (mq.size() != 0);
        s[1]   = (mq.size() == 4);
        s[2]   = m_ovr;
        s[3]   = m_perr;
        s[8:4] = 5'(mq.size());
        return s;
    endfunction

    initial begin
        logic [31:0] rd;
        logic [31:0] exp;
        logic [8:0]  f;
        logic [31:0] w;
        bit          pe;
        int          op;

        rst = 1'b1; rx_frame = '0; rx_ready = 1'b0;
        sel = 1'b0; addr = '0; re = 1'b0; we = 1'b0; wdata = '0;
        #1;
        checkOutput("reset_rdata", rdata, 32'h0);
        checkOutput("reset_irq", {31'd0, irq}, 32'h0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        busRead(4'h4, rd); checkOutput("reset_status", rd, 32'h0);
        busRead(4'h8, rd); checkOutput("reset_ctrl", rd, 32'h0);
        busRead(4'h0, rd); checkOutput("reset_data_empty", rd, 32'h0);

        vecs[0] = '{frame: 9'h0A5, exp_data: 32'h0A5, exp_status: 32'h011};
        vecs[1] = '{frame: 9'h1A5, exp_data: 32'h1A5, exp_status: 32'h019};
        vecs[2] = '{frame: 9'h000, exp_data: 32'h000, exp_status: 32'h011};
        vecs[3] = '{frame: 9'h1FF, exp_data: 32'h1FF, exp_status: 32'h019};
        vecs[4] = '{frame: 9'h101, exp_data: 32'h001, exp_status: 32'h011};
        vecs[5] = '{frame: 9'h001, exp_data: 32'h101, exp_status: 32'h019};

        busWrite(4'h8, 32'h1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].frame, 3);
            busRead(4'h4, rd); checkOutput($sformatf("vec%0d_status", i), rd, vecs[i].exp_status);
            busRead(4'h0, rd); checkOutput($sformatf("vec%0d_data", i), rd, vecs[i].exp_data);
            busWrite(4'h4, 32'h8);
            busRead(4'h4, rd); checkOutput($sformatf("vec%0d_cleared", i), rd, 32'h0);
        end

        // Parity-error set lands on the same edge as the clear write.
        rx_frame = 9'h1A5; rx_ready = 1'b1;
        tick();
        tick();
        sel = 1'b1; we = 1'b1; addr = 4'h4; wdata = 32'h8;
        tick();
        sel = 1'b0; we = 1'b0; wdata = '0; rx_ready = 1'b0;
        repeat (2) tick();
        busRead(4'h4, rd); checkOutput("perr_set_wins", rd, 32'h019);
        busRead(4'h0, rd); checkOutput("perr_set_wins_data", rd, 32'h1A5);
        busWrite(4'h4, 32'hC);

        for (int i = 1; i <= 5; i++) applyStimulus(goodFrame(8'(i)), 2);
        busRead(4'h4, rd); checkOutput("ovr_status", rd, 32'h047);
        for (int i = 1; i <= 4; i++) begin
            busRead(4'h0, rd); checkOutput($sformatf("ovr_read%0d", i), rd, 32'(i));
        end
        busRead(4'h0, rd); checkOutput("ovr_read_empty", rd, 32'h0);
        busRead(4'h4, rd); checkOutput("ovr_sticky", rd, 32'h004);
        busWrite(4'h4, 32'h4);
        busRead(4'h4, rd); checkOutput("ovr_cleared", rd, 32'h0);

        for (int i = 0; i < 4; i++) applyStimulus(goodFrame(8'h11 + 8'(i)), 2);
        rx_frame = goodFrame(8'h55); rx_ready = 1'b1;
        tick();
        tick();
        sel = 1'b1; re = 1'b1; addr = 4'h0;
        tick();
        sel = 1'b0; re = 1'b0; rx_ready = 1'b0;
        checkOutput("fullpop_data", rdata, 32'h011);
        repeat (3) tick();
        busRead(4'h4, rd); checkOutput("fullpop_status", rd, 32'h043);
        for (int i = 0; i < 3; i++) begin
            busRead(4'h0, rd); checkOutput($sformatf("fullpop_read%0d", i), rd, 32'h012 + 32'(i));
        end
        busRead(4'h0, rd); checkOutput("fullpop_last", rd, 32'h055);

        busWrite(4'h8, 32'h0);
        applyStimulus(goodFrame(8'h33), 2);
        busRead(4'h4, rd); checkOutput("rxdis_status", rd, 32'h0);
        busWrite(4'h8, 32'h3);
        applyStimulus(goodFrame(8'h66), 2);
        checkOutput("irq_high", {31'd0, irq}, 32'h1);
        busWrite(4'h8, 32'h7);
        tick();
        checkOutput("irq_after_flush", {31'd0, irq}, 32'h0);
        busRead(4'h4, rd); checkOutput("flush_status", rd, 32'h0);
        busRead(4'h8, rd); checkOutput("flush_reads_zero", rd, 32'h3);

        busWrite(4'h8, 32'h1);
        mq.delete(); m_ovr = 1'b0; m_perr = 1'b0;
        for (int n = 0; n < 150; n++) begin
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                f  = 9'($urandom_range(0, 511));
                pe = ^f;
                if (mq.size() < 4) mq.push_back({pe, f[7:0]});
                else m_ovr = 1'b1;
                if (pe) m_perr = 1'b1;
                applyStimulus(f, $urandom_range(1, 3));
            end else if (op <= 6) begin
                exp = (mq.size() == 0) ? 32'h0 : {23'd0, mq.pop_front()};
                busRead(4'h0, rd); checkOutput($sformatf("rand%0d_data", n), rd, exp);
            end else if (op <= 8) begin
                exp = modelStatus();
                busRead(4'h4, rd); checkOutput($sformatf("rand%0d_status", n), rd, exp);
            end else begin
                w = 32'($urandom_range(0, 3)) << 2;
                if (w[2]) m_ovr = 1'b0;
                if (w[3]) m_perr = 1'b0;
                busWrite(4'h4, w);
            end
        end
        busRead(4'h4, rd); checkOutput("rand_final_status", rd, modelStatus());

        busWrite(4'h8, 32'h3);
        busRead(4'h8, rd); checkOutput("pre_reset_ctrl", rd, 32'h3);
        while (mq.size() != 0) begin
            exp = {23'd0, mq.pop_front()};
            busRead(4'h0, rd); checkOutput("drain_data", rd, exp);
        end
        busWrite(4'h4, 32'hC);
        rx_frame = goodFrame(8'h77); rx_ready = 1'b1;
        tick();
        rst = 1'b1;
        #2;
        checkOutput("async_rst_rdata", rdata, 32'h0);
        checkOutput("async_rst_irq", {31'd0, irq}, 32'h0);
        rx_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        busWrite(4'h8, 32'h1);
        repeat (4) tick();
        busRead(4'h4, rd); checkOutput("after_rst_status", rd, 32'h0);
        busRead(4'h8, rd); checkOutput("after_rst_ctrl", rd, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
